cart_bus_bridge: RTL and testbench

Multi-channel bridge between asynchronous cartridge-side byte buses (PRG, CHR, …) and the single 16-bit toggle-handshake `sdram_bus` controller port. Each channel synchronises its strobes, qualifies reads by address stability, and captures writes on strobe release. Requests are round-robin arbitrated onto SDRAM, and each channel keeps the last fetched word. Sits between the cartridge pin logic and the SDRAM controller, replacing the per-bus single-channel bridges.

---
 rtl/cart_bus_bridge.sv | 172 +++++++++++++++++
 tb/tb_cart_bus_bridge.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_bus_bridge.sv
// cart_bus_bridge: N cartridge byte buses -> one 16-bit toggle-handshake SDRAM port; CART_BRIDGE_READ_CACHE_EN adds per-channel word tags
module cart_bus_bridge #(
  parameter int ADDR_BITS     = 23,
  parameter int NUM_CH        = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  output logic                             ram_req_o,
  input  logic                             ram_ack_i,
  output logic                             ram_we_o,
  output logic [ADDR_BITS-2:0]             ram_address_o,
  output logic [15:0]                      ram_data_write_o,
  output logic [1:0]                       ram_wm_o,
  input  logic [15:0]                      ram_data_read_i,
  input  logic [NUM_CH-1:0][ADDR_BITS-1:0] addr_i,
  input  logic [NUM_CH-1:0][7:0]           data_in_i,
  output logic [NUM_CH-1:0][7:0]           data_out_o,
  input  logic [NUM_CH-1:0]                ce_i,
  input  logic [NUM_CH-1:0]                oe_i,
  input  logic [NUM_CH-1:0]                we_i,
  output logic [NUM_CH-1:0]                overrun_o
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WA = ADDR_BITS - 1;
  logic [NUM_CH-1:0][1:0]           rd_sync_q, wr_sync_q;
  logic [NUM_CH-1:0]                wr_prev_q;
  logic [NUM_CH-1:0][ADDR_BITS-1:0] g1_q, g2_q, g3_q;
  logic [NUM_CH-1:0][2:0]           cnt_q;
  logic [NUM_CH-1:0]                rd_pend_q, wr_pend_q, overrun_q, wr_lsb_q;
  logic [NUM_CH-1:0][WA-1:0]        rd_addr_q, wr_addr_q;
  logic [NUM_CH-1:0][7:0]           wr_data_q;
  logic [NUM_CH-1:0][15:0]          word_q;
`ifdef CART_BRIDGE_READ_CACHE_EN
  logic [NUM_CH-1:0][WA-1:0]        tag_q;
  logic [NUM_CH-1:0]                valid_q;
`endif
  logic                             req_q, we_q, busy_q;
  logic [WA-1:0]                    address_q;
  logic [15:0]                      wdata_q;
  logic [1:0]                       wm_q;
  logic [CW-1:0]                    owner_q, ptr_q, gnt;
  logic [NUM_CH-1:0]                stable, post, fall, pend;
  logic                             idle, done, gnt_vld;
  assign ram_req_o        = req_q;
  assign ram_we_o         = we_q;
  assign ram_address_o    = address_q;
  assign ram_data_write_o = wdata_q;
  assign ram_wm_o         = wm_q;
  assign overrun_o        = overrun_q;
  // per-channel qualifiers and the live byte select of the held word
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      stable[c]     = rd_sync_q[c][1] && (g2_q[c] == g3_q[c]);
      post[c]       = stable[c] && (cnt_q[c] == 3'(STABLE_CYCLES - 1));
      fall[c]       = wr_prev_q[c] && !wr_sync_q[c][1];
      pend[c]       = wr_pend_q[c] || rd_pend_q[c];
      data_out_o[c] = addr_i[c][0] ? word_q[c][15:8] : word_q[c][7:0];
    end
  end
  // round-robin pick: the first pending channel at or after the pointer
  always_comb begin : arb
    int idx;
    idle    = !busy_q && (req_q == ram_ack_i);
    done    = busy_q && (req_q == ram_ack_i);
    gnt_vld = 1'b0;
    gnt     = ptr_q;
    idx     = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_CH) idx -= NUM_CH;
      if (pend[idx]) begin
        gnt_vld = 1'b1;
        gnt     = CW'(idx);
      end
    end
  end
  // strobe/address synchronisers and the address-stability counter
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_sync_q <= '0;
      wr_sync_q <= '0;
      wr_prev_q <= '0;
      g1_q      <= '0;
      g2_q      <= '0;
      g3_q      <= '0;
      cnt_q     <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        rd_sync_q[c] <= {rd_sync_q[c][0], ce_i[c] & ~oe_i[c]};
        wr_sync_q[c] <= {wr_sync_q[c][0], ce_i[c] & we_i[c]};
        wr_prev_q[c] <= wr_sync_q[c][1];
        g1_q[c]      <= addr_i[c] ^ (addr_i[c] >> 1);
        g2_q[c]      <= g1_q[c];
        g3_q[c]      <= g2_q[c];
        cnt_q[c]     <= !stable[c] ? 3'd0 : (cnt_q[c] == 3'(STABLE_CYCLES)) ? cnt_q[c] : cnt_q[c] + 3'd1;
      end
    end
  // request capture, issue onto the SDRAM port and read completion
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      address_q <= '0;
      wdata_q   <= '0;
      wm_q      <= '0;
      busy_q    <= 1'b0;
      owner_q   <= '0;
      ptr_q     <= '0;
      rd_pend_q <= '0;
      wr_pend_q <= '0;
      overrun_q <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_lsb_q  <= '0;
      wr_data_q <= '0;
      word_q    <= '0;
`ifdef CART_BRIDGE_READ_CACHE_EN
      tag_q     <= '0;
      valid_q   <= '0;
`endif
    end else begin
      if (done) begin
        busy_q <= 1'b0;
        if (!we_q) begin
          word_q[owner_q] <= ram_data_read_i;
          // a newer address posted while in flight stays pending
          if (rd_addr_q[owner_q] == address_q) rd_pend_q[owner_q] <= 1'b0;
`ifdef CART_BRIDGE_READ_CACHE_EN
          tag_q[owner_q]   <= address_q;
          valid_q[owner_q] <= 1'b1;
`endif
        end
      end
      if (idle && gnt_vld) begin
        req_q     <= ~req_q;
        busy_q    <= 1'b1;
        owner_q   <= gnt;
        ptr_q     <= (gnt == CW'(NUM_CH - 1)) ? '0 : gnt + CW'(1);
        we_q      <= wr_pend_q[gnt];
        address_q <= wr_pend_q[gnt] ? wr_addr_q[gnt] : rd_addr_q[gnt];
        if (wr_pend_q[gnt]) begin
          wdata_q        <= {2{wr_data_q[gnt]}};
          wm_q           <= wr_lsb_q[gnt] ? 2'b01 : 2'b10;
          wr_pend_q[gnt] <= 1'b0;
`ifdef CART_BRIDGE_READ_CACHE_EN
          for (int c = 0; c < NUM_CH; c++)
            if (tag_q[c] == wr_addr_q[gnt]) valid_q[c] <= 1'b0;
`endif
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (fall[c]) begin
          if (wr_pend_q[c]) overrun_q[c] <= 1'b1;
          else begin
            wr_pend_q[c] <= 1'b1;
            wr_addr_q[c] <= addr_i[c][ADDR_BITS-1:1];
            wr_lsb_q[c]  <= addr_i[c][0];
            wr_data_q[c] <= data_in_i[c];
          end
        end
`ifdef CART_BRIDGE_READ_CACHE_EN
        if (post[c] && !(valid_q[c] && tag_q[c] == addr_i[c][ADDR_BITS-1:1])) begin
`else
        if (post[c]) begin
`endif
          rd_pend_q[c] <= 1'b1;
          rd_addr_q[c] <= addr_i[c][ADDR_BITS-1:1];
        end
      end
    end
endmodule

// File: tb/tb_cart_bus_bridge.sv
// tb_cart_bus_bridge: randomized bench for cart_bus_bridge with an SDRAM responder and a byte-memory reference model
module tb_cart_bus_bridge;
  localparam int AB = 23;
  localparam int NC = 2;
  typedef struct {
    logic        we;
    logic [21:0] a;
    logic [15:0] wd;
    logic [1:0]  wm;
  } txn_t;
  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 ram_req, ram_ack, ram_we;
  logic [AB-2:0]        ram_address;
  logic [15:0]          ram_data_write, ram_data_read;
  logic [1:0]           ram_wm;
  logic [NC-1:0][AB-1:0] addr;
  logic [NC-1:0][7:0]   data_in, data_out;
  logic [NC-1:0]        ce, oe, we, overrun;
  int                   checks = 0, failures = 0, proto_err = 0;
  txn_t                 txq[$];
  logic [15:0]          sdram[logic [21:0]];
  logic [15:0]          ref_mem[logic [21:0]];
  logic                 seen;
  int                   lat;
  bit                   hold;
  bit                   val_m[NC];
  logic [21:0]          tag_m[NC];
  always #5 clk = ~clk;
  cart_bus_bridge #(.ADDR_BITS(AB), .NUM_CH(NC), .STABLE_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .ram_req_o(ram_req), .ram_ack_i(ram_ack), .ram_we_o(ram_we),
    .ram_address_o(ram_address), .ram_data_write_o(ram_data_write),
    .ram_wm_o(ram_wm), .ram_data_read_i(ram_data_read),
    .addr_i(addr), .data_in_i(data_in), .data_out_o(data_out),
    .ce_i(ce), .oe_i(oe), .we_i(we), .overrun_o(overrun)
  );
  function automatic logic [15:0] dflt(logic [21:0] w);
    return (w == 22'h80) ? 16'hA55A : ({w[7:0], w[15:8]} ^ 16'h6C93);
  endfunction
  function automatic logic [15:0] ref_word(logic [21:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : dflt(w);
  endfunction
  function automatic logic [7:0] ref_byte(logic [22:0] a);
    logic [15:0] w;
    w = ref_word(a[22:1]);
    return a[0] ? w[15:8] : w[7:0];
  endfunction
  function automatic void model_write(logic [22:0] a, logic [7:0] d);
    logic [15:0] w;
    w = ref_word(a[22:1]);
    if (a[0]) w[15:8] = d;
    else w[7:0] = d;
    ref_mem[a[22:1]] = w;
    for (int c = 0; c < NC; c++) if (tag_m[c] == a[22:1]) val_m[c] = 1'b0;
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // SDRAM side: accepts one toggle request, acks after 3 cycles unless held
  initial begin
    ram_ack = 1'b0;
    ram_data_read = '0;
    seen = 1'b0;
    lat = -1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        ram_ack = 1'b0;
        seen = 1'b0;
        lat = -1;
      end else if (lat >= 0 && ram_req !== seen) begin
        proto_err++;
      end else if (lat < 0 && ram_req !== seen) begin
        seen = ram_req;
        txq.push_back('{we: ram_we, a: ram_address, wd: ram_data_write, wm: ram_wm});
        lat = 3;
      end else if (lat > 0) begin
        lat--;
      end else if (lat == 0 && !hold) begin
        if (ram_we) begin
          logic [15:0] w;
          w = sdram.exists(ram_address) ? sdram[ram_address] : dflt(ram_address);
          if (!ram_wm[1]) w[15:8] = ram_data_write[15:8];
          if (!ram_wm[0]) w[7:0] = ram_data_write[7:0];
          sdram[ram_address] = w;
        end else begin
          ram_data_read = sdram.exists(ram_address) ? sdram[ram_address] : dflt(ram_address);
        end
        ram_ack = seen;
        lat = -1;
      end
    end
  end
  task automatic wait_txn(int n, output bit ok);
    for (int i = 0; i < 80 && txq.size() < n; i++) @(negedge clk);
    ok = txq.size() >= n;
  endtask
  task automatic wait_idle(output bit ok);
    for (int i = 0; i < 80 && !(lat < 0 && ram_req === seen); i++) @(negedge clk);
    ok = (lat < 0 && ram_req === seen);
    repeat (2) @(negedge clk);
  endtask
  task automatic chk_wr(int i, logic [22:0] a, logic [7:0] d);
    chk("wr_we", 32'(txq[i].we), 32'd1);
    chk("wr_addr", 32'(txq[i].a), 32'(a[22:1]));
    chk("wr_data", 32'(txq[i].wd), 32'({d, d}));
    chk("wr_mask", 32'(txq[i].wm), a[0] ? 32'd1 : 32'd2);
  endtask
  task automatic strobe_write(int ch, logic [22:0] a, logic [7:0] d);
    addr[ch] = a;
    data_in[ch] = d;
    @(negedge clk);
    ce[ch] = 1'b1;
    we[ch] = 1'b1;
    repeat (3) @(negedge clk);
    ce[ch] = 1'b0;
    we[ch] = 1'b0;
  endtask
  task automatic do_write(int ch, logic [22:0] a, logic [7:0] d);
    int n0;
    bit ok;
    n0 = txq.size();
    strobe_write(ch, a, d);
    wait_txn(n0 + 1, ok);
    chk("wr_issue", 32'(ok), 32'd1);
    if (ok) chk_wr(n0, a, d);
    wait_idle(ok);
    chk("wr_idle", 32'(ok), 32'd1);
    model_write(a, d);
  endtask
  task automatic do_read(int ch, logic [22:0] a);
    int n0;
    bit ok, hit;
    hit = 1'b0;
`ifdef CART_BRIDGE_READ_CACHE_EN
    hit = val_m[ch] && tag_m[ch] == a[22:1];
`endif
    n0 = txq.size();
    addr[ch] = a;
    @(negedge clk);
    ce[ch] = 1'b1;
    oe[ch] = 1'b0;
    if (!hit) begin
      wait_txn(n0 + 1, ok);
      chk("rd_issue", 32'(ok), 32'd1);
      if (ok) begin
        chk("rd_we", 32'(txq[n0].we), 32'd0);
        chk("rd_addr", 32'(txq[n0].a), 32'(a[22:1]));
      end
      wait_idle(ok);
      chk("rd_idle", 32'(ok), 32'd1);
    end else begin
      repeat (20) @(negedge clk);
      chk("rd_cached_noreq", 32'(txq.size()), 32'(n0));
    end
    chk("rd_data", 32'(data_out[ch]), 32'(ref_byte(a)));
    tag_m[ch] = a[22:1];
    val_m[ch] = 1'b1;
    ce[ch] = 1'b0;
    oe[ch] = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int n0;
    bit ok;
    logic [22:0] a0, a1, base;
    ce = '0;
    oe = '1;
    we = '0;
    addr = '0;
    data_in = '0;
    hold = 1'b0;
    for (int c = 0; c < NC; c++) begin
      val_m[c] = 1'b0;
      tag_m[c] = '0;
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_req", 32'(ram_req), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_address), 32'd0);
    chk("rst_wdata", 32'(ram_data_write), 32'd0);
    chk("rst_wm", 32'(ram_wm), 32'd0);
    chk("rst_dout0", 32'(data_out[0]), 32'd0);
    chk("rst_dout1", 32'(data_out[1]), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    do_read(0, 23'h000101);
    chk("rd_a55a", 32'(data_out[0]), 32'hA5);
    do_write(1, 23'h000200, 8'h3C);
    n0 = txq.size();
    hold = 1'b1;
    strobe_write(1, 23'h000300, 8'h11);
    wait_txn(n0 + 1, ok);
    chk("ovr_first_issue", 32'(ok), 32'd1);
    if (ok) chk_wr(n0, 23'h000300, 8'h11);
    strobe_write(1, 23'h000305, 8'h22);
    repeat (6) @(negedge clk);
    strobe_write(1, 23'h000306, 8'h33);
    repeat (6) @(negedge clk);
    chk("overrun_set", 32'(overrun), 32'b10);
    hold = 1'b0;
    wait_txn(n0 + 2, ok);
    chk("ovr_second_issue", 32'(ok), 32'd1);
    if (ok) chk_wr(n0 + 1, 23'h000305, 8'h22);
    wait_idle(ok);
    repeat (10) @(negedge clk);
    chk("ovr_dropped", 32'(txq.size()), 32'(n0 + 2));
    model_write(23'h000300, 8'h11);
    model_write(23'h000305, 8'h22);
    a0 = 23'h400000 | 23'($urandom_range(0, 65535));
    a1 = 23'h500000 | 23'($urandom_range(0, 65535));
    n0 = txq.size();
    addr[0] = a0;
    addr[1] = a1;
    @(negedge clk);
    ce = '1;
    oe = '0;
    wait_txn(n0 + 2, ok);
    chk("rr_both_issued", 32'(ok), 32'd1);
    if (ok) begin
      chk("rr_first_ch0", 32'(txq[n0].a), 32'(a0[22:1]));
      chk("rr_second_ch1", 32'(txq[n0 + 1].a), 32'(a1[22:1]));
    end
    wait_idle(ok);
    chk("rr_dout0", 32'(data_out[0]), 32'(ref_byte(a0)));
    chk("rr_dout1", 32'(data_out[1]), 32'(ref_byte(a1)));
    tag_m[0] = a0[22:1];
    tag_m[1] = a1[22:1];
    val_m[0] = 1'b1;
    val_m[1] = 1'b1;
    ce = '0;
    oe = '1;
    repeat (4) @(negedge clk);
    n0 = txq.size();
    for (int i = 0; i < 56; i++) begin
      addr[0] = i[0] ? 23'h2AAAAA : 23'h155555;
      if (i == 0) begin
        ce[0] = 1'b1;
        oe[0] = 1'b0;
      end
      if (i == 50) begin
        ce[0] = 1'b0;
        oe[0] = 1'b1;
      end
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("unstable_noreq", 32'(txq.size()), 32'(n0));
    do_read(0, 23'h000101);
    do_read(0, 23'h000101);
    do_write(1, 23'h000100, 8'h5E);
    do_read(0, 23'h000101);
    do_read(0, 23'h000100);
    base = 23'h300000 | (23'($urandom_range(0, 4095)) << 4);
    for (int i = 0; i < 24; i++) begin
      int ch;
      logic [22:0] a;
      ch = $urandom_range(0, NC - 1);
      a = base + 23'($urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0) do_write(ch, a, 8'($urandom));
      else do_read(ch, a);
    end
    chk("one_outstanding", 32'(proto_err), 32'd0);
    chk("overrun_sticky", 32'(overrun), 32'b10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
